ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-master AHB-Lite initiator: the bus-driving counterpart to the block-RAM slave memory.
- Converts a simple valid/ready command stream into pipelined AHB-Lite SINGLE transfers, overlapping address phase N+1 with data phase N.
- Returns exactly one response per accepted command: read data and error flag.
- Sits between a processor-less engine (DMA or snake-game logic) and the AHB-Lite decoder/mux.

Parameters:
- ADDR_W, 32, width of HADDR and cmd_addr.
- HPROT_VAL, 4'b0011, constant value driven on HPROT.

Ports:
- HCLK  in  1  system clock, all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  32  right-aligned write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  right-aligned, zero-extended read data (0 for writes)
- rsp_error  out  1  bus error or locally rejected command
- HADDR  out  ADDR_W;  HTRANS  out  2;  HWRITE  out  1;  HSIZE  out  3;  HBURST  out  3;  HPROT  out  4;  HMASTLOCK  out  1;  HWDATA  out  32
- HRDATA  in  32;  HREADY  in  1;  HRESP  in  1

Behaviour:
- Reset: all registers clear. HTRANS = IDLE, HADDR / HWRITE / HSIZE / HWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
- Reset mid-transfer abandons both slots; no response is produced for them.
- Constant outputs: HBURST = 3'b000 (SINGLE), HMASTLOCK = 0, HPROT = HPROT_VAL.
- Two pipeline slots, A (address phase) and D (data phase).
- cmd_ready = ~A_valid | HREADY. An accepted command loads A on the same edge.
- A drives HADDR / HWRITE / HSIZE. HTRANS = NONSEQ when A_valid & ~A_bad, else IDLE.
- A fields are held stable while HREADY = 0.
- A moves to D on an edge with HREADY = 1. A empties unless a new command is accepted on that edge.
- A_bad (local reject) is set when any of these holds:
  - cmd_size = 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
- A_bad commands are never issued (HTRANS = IDLE) but still flow through D to keep ordering.
- HWDATA is driven from D during the data phase:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: as-is.
  - HWDATA = 0 when D is empty.
- D completes on an edge with HREADY = 1. On the next cycle rsp_valid = 1 with:
  - rsp_error = (HRESP seen in this data phase) | D_bad;
  - rsp_rdata = the addressed HRDATA lane per size/addr[1:0], right-aligned and zero-extended. It is 0 for writes and errors.
- Latency with zero wait states: command accepted at edge 0 -> NONSEQ in cycle 0–1 -> data phase in cycle 1–2 -> rsp_valid in cycle 2–3.
- Back-to-back commands sustain one transfer per cycle.
- Wait states: HREADY low stalls both slots; cmd_ready = ~A_valid.
- Error: two-cycle HRESP (cycle 1: HRESP = 1, HREADY = 0; cycle 2: HRESP = 1, HREADY = 1) latches an error flag for D. Without the optional feature, the pending A transfer is still issued normally.
- Simultaneous events: acceptance into A and A->D advance on the same edge are legal. D completion and A->D advance on the same edge are legal.

Optional Feature:
- Macro: AHB_MASTER_ERR_CANCEL_EN.
- Defined: in the first error cycle (HRESP = 1, HREADY = 0), a valid A slot is marked cancelled and HTRANS drops to IDLE from the next cycle.
  - The cancelled command still traverses D with no bus access.
  - It responds with rsp_error = 1 one cycle after the errored response.
  - cmd_ready = 0 during the two error cycles.
- Undefined: no cancellation; the pending transfer proceeds as issued.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS_IDLE / NONSEQ;
  - HSIZE_BYTE / HALF / WORD;
  - HBURST_SINGLE;
  - HRESP_OKAY / ERROR;
  - the cmd_size encodings.
- Natural sub-module ahb_lane_mux: combinational write-lane replication and read-lane extraction from size and addr[1:0]. It is reused by later AHB blocks.

Test Plan:
- Word write 0x00000100 <- 0xDEADBEEF, zero wait -> NONSEQ/HWRITE = 1/HSIZE = 2 one cycle after accept; HWDATA = 0xDEADBEEF next cycle; rsp_valid = 1, rsp_error = 0.
- Back-to-back reads 0x0, 0x4, 0x8 with slave returning 0x11, 0x22, 0x33 -> three consecutive NONSEQ cycles; three consecutive rsp_valid with rdata 0x11, 0x22, 0x33.
- Byte read at 0x103 with HRDATA = 0xAABBCCDD, two wait states -> HADDR held 2 cycles; rsp_rdata = 0x000000AA.
- Half write 0x102 data 0x1234 -> HWDATA = 0x12341234. Then a word read at 0x6 -> HTRANS stays IDLE; rsp_error = 1, rsp_rdata = 0.
- Two-cycle ERROR on read 0x10 with read 0x14 pending -> first rsp_error = 1. Second is issued OK (macro undefined) or cancelled with rsp_error = 1 (macro defined).
- HRESET asserted during wait state -> next cycle HTRANS = IDLE, no rsp_valid; a fresh command afterwards completes normally.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings plus the local command encodings used by the
// command-stream master and the lane mux.
//   - HTRANS / HSIZE / HBURST / HRESP constants
//   - cmd_size_e : command size field (3 = illegal)
//   - slot_t     : one pipeline slot (address or data phase)
//   - cmd_is_bad : local alignment / size rejection
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    CMD_BYTE    = 2'd0,
    CMD_HALF    = 2'd1,
    CMD_WORD    = 2'd2,
    CMD_ILLEGAL = 2'd3
  } cmd_size_e;

  // Everything a transfer needs after it leaves the address phase; the full
  // address only lives in the address slot, the data slot keeps the low bits.
  typedef struct packed {
    logic        valid;
    logic        bad;     // rejected locally, never put on the bus
    logic        cancel;  // dropped after an earlier bus error
    logic        write;
    cmd_size_e   size;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } slot_t;

  function automatic logic cmd_is_bad(input cmd_size_e size, input logic [1:0] lo);
    case (size)
      CMD_BYTE: return 1'b0;
      CMD_HALF: return lo[0];
      CMD_WORD: return |lo;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command/response stream plus AHB-Lite bus signals of ahb_lite_master.
//   modport master : the initiator (drives cmd_ready, rsp_*, H* address/data)
//   modport slave  : the environment (drives cmd_*, HRDATA/HREADY/HRESP)
interface ahb_lite_master_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lane_mux.sv
// Byte-lane steering for a 32-bit AHB data bus.
//   size   : cmd size (byte/half/word; illegal passes through as word)
//   lane   : address bits [1:0]
//   wdata  : right-aligned write data -> hwdata replicated on every lane
//   hrdata : raw bus read data        -> rdata right-aligned, zero-extended
module ahb_lane_mux
  import ahb_lite_pkg::*;
(
  input  cmd_size_e   size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] hrdata,
  output logic [31:0] hwdata,
  output logic [31:0] rdata
);
  always_comb begin
    hwdata = wdata;
    rdata  = hrdata;
    case (size)
      CMD_BYTE: begin
        hwdata = {4{wdata[7:0]}};
        case (lane)
          2'd0:    rdata = {24'd0, hrdata[7:0]};
          2'd1:    rdata = {24'd0, hrdata[15:8]};
          2'd2:    rdata = {24'd0, hrdata[23:16]};
          default: rdata = {24'd0, hrdata[31:24]};
        endcase
      end
      CMD_HALF: begin
        hwdata = {2{wdata[15:0]}};
        rdata  = lane[1] ? {16'd0, hrdata[31:16]} : {16'd0, hrdata[15:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/ahb_lite_master.sv
// Single-master AHB-Lite initiator: turns a valid/ready command stream into
// pipelined SINGLE transfers, one response pulse per accepted command.
//   HCLK, HRESET : clock, synchronous active-high reset
//   bus          : ahb_lite_master_if.master (cmd_*, rsp_*, AHB-Lite signals)
// Params: ADDR_W (address width), HPROT_VAL (constant HPROT).
// Build option: AHB_MASTER_ERR_CANCEL_EN - on the first ERROR cycle the
// pending address-phase command is cancelled (no bus access, error response).
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_lite_master_if.master bus
);
  slot_t             a_q, d_q, cmd_slot;
  logic [ADDR_W-1:0] a_addr_q;
  logic              d_err_q;
  logic              rsp_valid_q, rsp_error_q;
  logic [31:0]       rsp_rdata_q;
  logic              accept, a_issue, d_fail, hresp_err;
  logic [31:0]       hwdata_rep, rdata_ext;

  assign hresp_err = (bus.HRESP == HRESP_ERROR);

`ifdef AHB_MASTER_ERR_CANCEL_EN
  // Hold the stream off for both error cycles so nothing new slips in
  // behind the transfer being cancelled.
  assign bus.cmd_ready = (~a_q.valid | bus.HREADY) & ~hresp_err;
`else
  assign bus.cmd_ready = ~a_q.valid | bus.HREADY;
`endif
  assign accept = bus.cmd_valid & bus.cmd_ready;

  always_comb begin
    cmd_slot        = '0;
    cmd_slot.valid  = 1'b1;
    cmd_slot.size   = cmd_size_e'(bus.cmd_size);
    cmd_slot.bad    = cmd_is_bad(cmd_size_e'(bus.cmd_size), bus.cmd_addr[1:0]);
    cmd_slot.write  = bus.cmd_write;
    cmd_slot.lane   = bus.cmd_addr[1:0];
    cmd_slot.wdata  = bus.cmd_wdata;
  end

  ahb_lane_mux u_lane (
    .size   (d_q.size),
    .lane   (d_q.lane),
    .wdata  (d_q.wdata),
    .hrdata (bus.HRDATA),
    .hwdata (hwdata_rep),
    .rdata  (rdata_ext)
  );

  // Rejected/cancelled slots never touched the bus; HRESP is only ever
  // non-OKAY for a real transfer, so ORing it in unconditionally is safe.
  assign d_fail = d_q.bad | d_q.cancel | d_err_q | hresp_err;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_q         <= '0;
      d_q         <= '0;
      a_addr_q    <= '0;
      d_err_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (bus.HREADY) begin
        if (d_q.valid) begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= d_fail;
          rsp_rdata_q <= (d_fail | d_q.write) ? '0 : rdata_ext;
        end
        d_q     <= a_q;
        d_err_q <= 1'b0;
        if (accept) begin
          a_q      <= cmd_slot;
          a_addr_q <= bus.cmd_addr;
        end else begin
          a_q.valid <= 1'b0;
        end
      end else begin
        // First cycle of a two-cycle ERROR response.
        if (d_q.valid && hresp_err) d_err_q <= 1'b1;
`ifdef AHB_MASTER_ERR_CANCEL_EN
        if (a_q.valid && hresp_err) a_q.cancel <= 1'b1;
`endif
        // Only reachable with A empty: a command may enter during a stall.
        if (accept) begin
          a_q      <= cmd_slot;
          a_addr_q <= bus.cmd_addr;
        end
      end
    end
  end

  assign a_issue       = a_q.valid & ~a_q.bad & ~a_q.cancel;
  assign bus.HTRANS    = a_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_addr_q;
  assign bus.HWRITE    = a_q.write;
  assign bus.HSIZE     = {1'b0, a_q.size};
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = d_q.valid ? hwdata_rep : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized + directed bench for ahb_lite_master. The bench plays the AHB
// slave and keeps a transaction-level model of the two in-flight commands.
module tb_ahb_lite_master;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_if #(.ADDR_W(32)) bus();
  ahb_lite_master #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

`ifdef AHB_MASTER_ERR_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  typedef struct {
    bit        wr;
    bit [1:0]  sz;
    bit [31:0] addr;
    bit [31:0] wd;
    bit        bad;
    bit        canc;
    int        waits;
    bit        err;
    bit [31:0] rd;
  } ent_t;

  typedef struct {
    bit [31:0] rd;
    bit        er;
    int        cyc;
  } rsp_t;

  int checks = 0;
  int errors = 0;

  // model: command in address phase (a) and in data phase (d)
  ent_t a_e, d_e;
  bit   a_v = 0, d_v = 0;
  int   d_cyc = 0;
  bit   exp_rv = 0, exp_re = 0;
  bit [31:0] exp_rd = 0;

  rsp_t rsp_log[$];
  bit [31:0] last_hwdata = 0;
  int   cyc_n = 0;
  int   acc_cyc = 0;
  bit   accepted = 0;

  // next command offered + slave plan for it
  bit        c_valid = 0, c_wr = 0;
  bit [1:0]  c_sz = 0;
  bit [31:0] c_addr = 0, c_wd = 0;
  int        p_waits = 0;
  bit        p_err = 0;
  bit [31:0] p_rd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic bit is_bad(input bit [1:0] sz, input bit [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 32'd0;
  endfunction

  function automatic bit [31:0] repl(input bit [1:0] sz, input bit [31:0] w);
    case (sz)
      2'd0:    return (w & 32'hFF) * 32'h01010101;
      2'd1:    return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic bit [31:0] lane_of(input bit [1:0] sz, input bit [1:0] lo, input bit [31:0] d);
    int sh;
    case (sz)
      2'd0: begin sh = 8 * int'(lo); return (d >> sh) & 32'hFF; end
      2'd1: begin sh = 16 * int'(lo[1]); return (d >> sh) & 32'hFFFF; end
      default: return d;
    endcase
  endfunction

  // One bus cycle: drive at negedge, compare 1 ns later, then advance the
  // model to what the following rising edge must produce.
  task automatic cycle(input bit rst);
    bit hr, hp, exp_ready, acc, issue;
    bit [31:0] hrd;
    ent_t ne;
    @(negedge HCLK);
    cyc_n++;
    if (d_v && !d_e.bad && !d_e.canc) begin
      if (d_e.err) begin hp = 1'b1; hr = (d_cyc >= 1); end
      else begin hp = 1'b0; hr = (d_cyc >= d_e.waits); end
    end else begin
      hp = 1'b0; hr = 1'b1;
    end
    hrd = (hr && d_v) ? d_e.rd : $urandom;
    bus.HREADY    = hr;
    bus.HRESP     = hp;
    bus.HRDATA    = hrd;
    bus.cmd_valid = c_valid;
    bus.cmd_write = c_wr;
    bus.cmd_size  = c_sz;
    bus.cmd_addr  = c_addr;
    bus.cmd_wdata = c_wd;
    HRESET        = rst;
    #1;
    exp_ready = (!a_v || hr) && !(CANCEL && hp);
    issue     = a_v && !a_e.bad && !a_e.canc;
    if (!rst) begin
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
      chk("htrans", 32'(bus.HTRANS), issue ? 32'd2 : 32'd0);
      if (issue) begin
        chk("haddr", bus.HADDR, a_e.addr);
        chk("hwrite", 32'(bus.HWRITE), 32'(a_e.wr));
        chk("hsize", 32'(bus.HSIZE), 32'(a_e.sz));
      end
      if (!d_v) chk("hwdata_idle", bus.HWDATA, 32'd0);
      else if (d_e.wr && !d_e.bad && !d_e.canc) begin
        chk("hwdata", bus.HWDATA, repl(d_e.sz, d_e.wd));
        last_hwdata = bus.HWDATA;
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rsp_error", 32'(bus.rsp_error), 32'(exp_re));
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      end
      if (bus.rsp_valid === 1'b1) rsp_log.push_back('{rd: bus.rsp_rdata, er: bus.rsp_error, cyc: cyc_n});
    end
    acc      = c_valid && exp_ready && !rst;
    accepted = acc;
    ne = '{wr: c_wr, sz: c_sz, addr: c_addr, wd: c_wd, bad: is_bad(c_sz, c_addr),
           canc: 1'b0, waits: p_waits, err: p_err, rd: p_rd};
    exp_rv = 1'b0;
    if (rst) begin
      a_v = 1'b0; d_v = 1'b0; d_cyc = 0;
    end else if (hr) begin
      if (d_v) begin
        exp_rv = 1'b1;
        exp_re = d_e.bad || d_e.canc || hp;
        exp_rd = (exp_re || d_e.wr) ? 32'd0 : lane_of(d_e.sz, d_e.addr[1:0], hrd);
      end
      d_v = a_v; d_e = a_e; d_cyc = 0;
      a_v = acc;
      if (acc) a_e = ne;
    end else begin
      if (d_v) d_cyc++;
      if (CANCEL && hp && a_v) a_e.canc = 1'b1;
      if (acc) begin a_v = 1'b1; a_e = ne; end
    end
  endtask

  task automatic send(input bit wr, input bit [1:0] sz, input bit [31:0] addr,
                      input bit [31:0] wd, input int waits, input bit err, input bit [31:0] rd);
    c_valid = 1'b1; c_wr = wr; c_sz = sz; c_addr = addr; c_wd = wd;
    p_waits = waits; p_err = err; p_rd = rd;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) cycle(1'b0);
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted addr=%h", addr);
    end
    acc_cyc = cyc_n;
    c_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    c_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic chk_rsp(input string nm, input int idx, input bit [31:0] rd, input bit er);
    if (idx >= rsp_log.size()) begin
      checks++; errors++;
      $display("FAIL %s actual=no_response expected=response_%0d", nm, idx);
    end else begin
      chk({nm, "_rdata"}, rsp_log[idx].rd, rd);
      chk({nm, "_error"}, 32'(rsp_log[idx].er), 32'(er));
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_size = 2'd0;
    bus.cmd_addr = 32'd0; bus.cmd_wdata = 32'd0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'd0;

    for (int i = 0; i < 3; i++) cycle(1'b1);
    cycle(1'b0);
    chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst_haddr", bus.HADDR, 32'd0);
    chk("rst_hwrite_hsize", {28'd0, bus.HWRITE, bus.HSIZE}, 32'd0);
    chk("rst_hwdata", bus.HWDATA, 32'd0);
    chk("rst_rsp", {bus.rsp_rdata[30:0], bus.rsp_valid} | 32'(bus.rsp_error) | bus.rsp_rdata, 32'd0);
    chk("hburst", 32'(bus.HBURST), 32'd0);
    chk("hprot", 32'(bus.HPROT), 32'd3);
    chk("hmastlock", 32'(bus.HMASTLOCK), 32'd0);

    // word write, zero wait
    rsp_log.delete();
    send(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 1'b0, 32'd0);
    idle(5);
    chk_rsp("wr_word", 0, 32'd0, 1'b0);
    chk("wr_hwdata", last_hwdata, 32'hDEADBEEF);
    if (rsp_log.size() >= 1) chk("wr_latency", 32'(rsp_log[0].cyc - acc_cyc), 32'd3);

    // back-to-back reads
    rsp_log.delete();
    send(1'b0, 2'd2, 32'h0, 32'd0, 0, 1'b0, 32'h11);
    send(1'b0, 2'd2, 32'h4, 32'd0, 0, 1'b0, 32'h22);
    send(1'b0, 2'd2, 32'h8, 32'd0, 0, 1'b0, 32'h33);
    idle(5);
    chk_rsp("rd0", 0, 32'h11, 1'b0);
    chk_rsp("rd1", 1, 32'h22, 1'b0);
    chk_rsp("rd2", 2, 32'h33, 1'b0);
    if (rsp_log.size() >= 3) chk("rd_b2b_gap", 32'(rsp_log[2].cyc - rsp_log[0].cyc), 32'd2);

    // byte read with two wait states
    rsp_log.delete();
    send(1'b0, 2'd0, 32'h103, 32'd0, 2, 1'b0, 32'hAABBCCDD);
    idle(6);
    chk_rsp("rd_byte", 0, 32'h000000AA, 1'b0);

    // half write then misaligned word read
    rsp_log.delete();
    send(1'b1, 2'd1, 32'h102, 32'h1234, 0, 1'b0, 32'd0);
    send(1'b0, 2'd2, 32'h6, 32'd0, 0, 1'b0, 32'h99);
    idle(5);
    chk("half_hwdata", last_hwdata, 32'h12341234);
    chk_rsp("half_wr", 0, 32'd0, 1'b0);
    chk_rsp("bad_rd", 1, 32'd0, 1'b1);

    // two-cycle ERROR with a read pending behind it
    rsp_log.delete();
    send(1'b0, 2'd2, 32'h10, 32'd0, 0, 1'b1, 32'h77);
    send(1'b0, 2'd2, 32'h14, 32'd0, 0, 1'b0, 32'h55);
    idle(6);
    chk_rsp("err_first", 0, 32'd0, 1'b1);
    chk_rsp("err_second", 1, CANCEL ? 32'd0 : 32'h55, CANCEL);
    if (rsp_log.size() >= 2) chk("err_rsp_gap", 32'(rsp_log[1].cyc - rsp_log[0].cyc), 32'd1);

    // reset during a wait state
    rsp_log.delete();
    send(1'b0, 2'd0, 32'h40, 32'd0, 5, 1'b0, 32'h12345678);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    idle(6);
    chk("rst_mid_no_rsp", 32'(rsp_log.size()), 32'd0);
    send(1'b0, 2'd2, 32'h20, 32'd0, 1, 1'b0, 32'hCAFEF00D);
    idle(6);
    chk_rsp("after_rst", 0, 32'hCAFEF00D, 1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r, gap;
      bit [1:0] sz;
      bit [31:0] ad;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      r   = int'($urandom_range(0, 9));
      sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      ad  = $urandom;
      if ($urandom_range(0, 9) < 7 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
      for (int g = 0; g < gap; g++) idle(1);
      send(1'($urandom_range(0, 1)), sz, ad, $urandom,
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : 0,
           ($urandom_range(0, 7) == 0), $urandom);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
